// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite word RAM slave, 2**ADDR_BITS x 32, WAIT_STATES wait cycles.
// Ports: HCLK, HRESET (sync, active-high), HSEL/HADDR/HTRANS/HSIZE/
// HBURST/HWRITE/HWDATA in; HRDATA/HREADY/HRESP out.
// Define AHB_RAM_ERR_RESP_EN to answer bad size/alignment with ERROR.
module ahb_lite_ram_slave #(
   parameter int ADDR_BITS   = 6,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP
);

   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAST,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t state_q;
   state_t state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   logic [ADDR_BITS-1:0] idx_q;
   logic [3:0]           be_q;
   logic                 wr_q;
   logic [31:0]          hrdata_q;

   logic [31:0] mem [DEPTH];

   logic                 accept;
   logic                 bad;
   logic [ADDR_BITS-1:0] a_idx;
   logic [3:0]           a_be;
   logic                 we;
   logic                 rd_new;
   logic                 rd_old;
   logic [ADDR_BITS-1:0] rd_idx;
   logic [31:0]          rd_word;
   logic                 unused_bits;

   assign unused_bits = ^{HBURST, HADDR[31:ADDR_BITS+2]};

   assign accept = HSEL & HTRANS[1] & HREADY;
   assign a_idx  = HADDR[ADDR_BITS+1:2];

   // Lane strobes; oversize is a word, low bits masked to alignment.
   always_comb begin
      a_be = 4'b1111;
      unique case (1'b1)
         (HSIZE == 3'd0): a_be = 4'b0001 << HADDR[1:0];
         (HSIZE == 3'd1): a_be = HADDR[1] ? 4'b1100 : 4'b0011;
         default:         a_be = 4'b1111;
      endcase
   end

`ifdef AHB_RAM_ERR_RESP_EN
   assign bad = (HSIZE > 3'd2)
              | ((HSIZE == 3'd1) & HADDR[0])
              | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`else
   assign bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_WAIT: begin
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            if (cnt_q <= 4'd1)
               state_d = S_LAST;
         end
         S_LAST: state_d = S_IDLE;
         S_ERR1: state_d = S_ERR2;
         S_ERR2: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // HREADY gates accept, so this only fires in IDLE/LAST/ERR2.
      if (accept) begin
         if (bad) begin
            state_d = S_ERR1;
            cnt_d   = 4'd0;
         end else if (WS == 4'd0) begin
            state_d = S_LAST;
            cnt_d   = 4'd0;
         end else begin
            state_d = S_WAIT;
            cnt_d   = WS;
         end
      end
   end

   assign HREADY = (state_q != S_WAIT) && (state_q != S_ERR1);

`ifdef AHB_RAM_ERR_RESP_EN
   assign HRESP = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
   assign HRESP = 1'b0;
`endif

   assign we = (state_q == S_LAST) & wr_q & ~HRESET;

   // Read data is captured on the edge that enters LAST.
   assign rd_new = accept & ~bad & ~HWRITE & (WS == 4'd0);
   assign rd_old = (state_q == S_WAIT) & (cnt_q <= 4'd1) & ~wr_q;
   assign rd_idx = rd_new ? a_idx : idx_q;

   // Forward lanes being written this edge to a read of the same word.
   always_comb begin
      rd_word = mem[rd_idx];
      if (we && (idx_q == rd_idx)) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b])
               rd_word[8*b +: 8] = HWDATA[8*b +: 8];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b])
               mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         be_q     <= 4'd0;
         wr_q     <= 1'b0;
         hrdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            idx_q <= a_idx;
            be_q  <= a_be;
            wr_q  <= HWRITE;
         end
         if (rd_new | rd_old)
            hrdata_q <= rd_word;
      end
   end

   assign HRDATA = hrdata_q;

endmodule

// File: doc/ahb_lite_ram_slave.md
AHB_LITE_RAM_SLAVE -- requirements
Module: ahb_lite_ram_slave

Interface
REQ-001 Parameter ADDR_BITS, default 6, SHALL set the word-address width; depth = 2**ADDR_BITS 32-bit words (default 256 bytes).
REQ-002 Parameter WAIT_STATES, default 1, range 0..15, SHALL set the number of HREADY-low cycles inserted in every OKAY data phase.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 HCLK  in  1  clock; all logic on rising edge.
REQ-005 HRESET  in  1  synchronous active-high reset.
REQ-006 HADDR  in  32  byte address; only bits [ADDR_BITS+1:0] used, upper bits ignored (wrap).
REQ-007 HBURST  in  3  ignored; every beat is handled as a single transfer.
REQ-008 HSEL  in  1  slave select.
REQ-009 HSIZE  in  3  transfer size: 0 byte, 1 halfword, 2 word.
REQ-010 HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-011 HWDATA  in  32  write data, sampled in the data phase.
REQ-012 HWRITE  in  1  1 write, 0 read.
REQ-013 HRDATA  out  32  read data, valid when HREADY=1 in a read data phase.
REQ-014 HREADY  out  1  transfer-done / bus-ready; this is the only slave, so it is also the bus HREADY.
REQ-015 HRESP  out  1  0 OKAY, 1 ERROR.

Function
REQ-016 An address phase SHALL be accepted on a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1; address, size, write and byte offset are registered then.
REQ-017 FSM states: IDLE (HREADY=1, HRESP=0), WAIT (HREADY=0, HRESP=0, wait counter >0), LAST (HREADY=1, HRESP=0), ERR1 (HREADY=0, HRESP=1), ERR2 (HREADY=1, HRESP=1).
REQ-018 On accepted valid transfer: WAIT_STATES=0 -> LAST; else -> WAIT with counter=WAIT_STATES; WAIT decrements each cycle and moves to LAST when the counter reaches 1.
REQ-019 In LAST or ERR2, a new accepted address phase SHALL start the next transfer in the same edge (back-to-back pipelining); otherwise go to IDLE.
REQ-020 HTRANS IDLE/BUSY or HSEL=0 with HREADY=1 SHALL produce no transfer and keep/return to IDLE.
REQ-021 Writes SHALL update the array on the LAST edge using HWDATA and byte strobes: byte -> lane HADDR[1:0]; halfword -> lanes {HADDR[1],0},{HADDR[1],1}; word -> all four lanes.
REQ-022 Reads SHALL drive the full 32-bit word at the registered address on HRDATA during LAST; HRDATA holds its last value otherwise.
REQ-023 A read whose address phase is accepted on the same edge as a write completes to the same word SHALL return the newly written bytes (write-read bypass).
REQ-024 Arithmetic: wait counter 4 bits, saturating at 0; word index = HADDR[ADDR_BITS+1:2] modulo depth.

Reset
REQ-025 HRESET=1 on an edge SHALL force IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter=0 and drop any pending transfer without writing.
REQ-026 The memory array SHALL NOT be cleared by reset; contents survive reset mid-operation.
REQ-027 HRESET SHALL take priority over any simultaneous address phase.

Configuration
REQ-028 Macro AHB_RAM_ERR_RESP_EN defined: HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0 SHALL give ERR1 then ERR2 (two-cycle ERROR), with no write and HRDATA unchanged.
REQ-029 Macro AHB_RAM_ERR_RESP_EN undefined: HRESP SHALL be constant 0, ERR1/ERR2 unreachable, HSIZE>2 treated as word and misaligned low address bits masked to the size alignment.

Verification
REQ-030 WAIT_STATES=1: write 0xDEADBEEF to 0x10, then read 0x10 -> one HREADY-low cycle per beat, HRDATA=0xDEADBEEF, HRESP=0.
REQ-031 WAIT_STATES=0: back-to-back NONSEQ writes 0x00..0x80 step 4 with data=previous address, then reads -> HREADY never low, every read matches, 33 beats, 0 mismatches.
REQ-032 Byte write 0xAA to 0x21 over word 0x11223344 at 0x20 -> read 0x20 returns 0x1122AA44.
REQ-033 Write 0x5 to 0x08 immediately followed by read 0x08 -> read returns 0x00000005 (bypass).
REQ-034 With AHB_RAM_ERR_RESP_EN: word write to 0x06 -> HREADY/HRESP = 0/1 then 1/1, word at 0x04 unchanged; without the macro the same transfer writes the word at 0x04 and HRESP stays 0.
REQ-035 Assert HRESET during WAIT of a write to 0x0C -> next edge HREADY=1, HRDATA=0, word 0x0C keeps its old value; previously written 0x10 still reads 0xDEADBEEF.
